// File: rtl/drp_adc_responder_if.sv
// DRP request/response and ADC sample-push signals shared by initiator and responder.
// No storage: pure signal bundle, latency is set by the responder.
// No backpressure on either path; busy_out/overlap_err report a dropped request.
interface drp_adc_responder_if;
  logic        den_in;
  logic        dwe_in;
  logic [6:0]  daddr_in;
  logic [15:0] di_in;
  logic [15:0] do_out;
  logic        drdy_out;
  logic        busy_out;
  logic        sample_valid;
  logic        sample_ch;
  logic [11:0] sample_data;
  logic        eoc_out;
  logic [6:0]  channel_out;
  logic        overlap_err;

  modport slave (
    input  den_in, dwe_in, daddr_in, di_in,
    input  sample_valid, sample_ch, sample_data,
    output do_out, drdy_out, busy_out,
    output eoc_out, channel_out, overlap_err
  );

  modport master (
    output den_in, dwe_in, daddr_in, di_in,
    output sample_valid, sample_ch, sample_data,
    input  do_out, drdy_out, busy_out,
    input  eoc_out, channel_out, overlap_err
  );
endinterface

// File: rtl/drp_adc_responder.sv
// DRP responder emulating XADC aux6/aux7 result and config registers (DRP_WRITE_EN enables config writes).
// Latency: drdy_out exactly READ_LATENCY cycles after the den_in cycle; eoc_out one cycle after sample_valid.
// Backpressure: none; den_in while busy is dropped and flagged in sticky overlap_err.
module drp_adc_responder #(
  parameter int          READ_LATENCY = 4,
  parameter logic [15:0] CFG0_RESET   = 16'h0000,
  parameter logic [15:0] CFG1_RESET   = 16'h0000
) (
  input logic             clk_100MHz,
  input logic             rst,
  drp_adc_responder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(READ_LATENCY - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        accept;
  logic [15:0] rd_val;
  logic [15:0] hold_q;
  logic        we_q;
  logic [15:0] aux6_q, aux7_q;
  logic [15:0] cfg0_q, cfg1_q;
  logic        eoc_q;
  logic [6:0]  chan_q;
  logic        ovl_q;
`ifdef DRP_WRITE_EN
  logic [6:0]  addr_q;
  logic [15:0] di_q;
`endif

  // Register read mux evaluated in the den_in cycle (read snapshot source).
  always_comb begin
    rd_val = 16'h0000;
    case (bus.daddr_in)
      7'h16:   rd_val = aux6_q;
      7'h17:   rd_val = aux7_q;
      7'h40:   rd_val = cfg0_q;
      7'h41:   rd_val = cfg1_q;
      default: rd_val = 16'h0000;
    endcase
  end

  // Next-state logic: accept in IDLE, count down in WAIT, single response cycle in RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.den_in) begin
          accept  = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = (READ_LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        // Counter reaching zero on this decrement means the next cycle responds.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register and counter.
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the request; reads snapshot the register now so later samples stay invisible.
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      hold_q <= 16'h0000;
      we_q   <= 1'b0;
`ifdef DRP_WRITE_EN
      addr_q <= 7'h00;
      di_q   <= 16'h0000;
`endif
    end else if (accept) begin
      hold_q <= bus.dwe_in ? 16'h0000 : rd_val;
      we_q   <= bus.dwe_in;
`ifdef DRP_WRITE_EN
      addr_q <= bus.daddr_in;
      di_q   <= bus.di_in;
`endif
    end
  end

  // Sticky flag for requests arriving while a transaction is in flight.
  always_ff @(posedge clk_100MHz) begin
    if (rst)                                  ovl_q <= 1'b0;
    else if (bus.den_in && state_q != IDLE)   ovl_q <= 1'b1;
  end

  // Config registers; writes land only in the response cycle, so a reset before it discards them.
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      cfg0_q <= CFG0_RESET;
      cfg1_q <= CFG1_RESET;
    end else begin
`ifdef DRP_WRITE_EN
      if (state_q == RESP && we_q) begin
        if (addr_q == 7'h40) cfg0_q <= di_q;
        if (addr_q == 7'h41) cfg1_q <= di_q;
      end
`endif
    end
  end

  // Sample path, independent of the DRP FSM: store result, pulse eoc and report channel next cycle.
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      aux6_q <= 16'h0000;
      aux7_q <= 16'h0000;
      eoc_q  <= 1'b0;
      chan_q <= 7'h00;
    end else begin
      eoc_q <= bus.sample_valid;
      if (bus.sample_valid) begin
        if (bus.sample_ch) aux7_q <= {bus.sample_data, 4'b0000};
        else               aux6_q <= {bus.sample_data, 4'b0000};
        chan_q <= bus.sample_ch ? 7'h17 : 7'h16;
      end
    end
  end

  assign bus.drdy_out    = (state_q == RESP);
  assign bus.do_out      = (state_q == RESP && !we_q) ? hold_q : 16'h0000;
  assign bus.busy_out    = (state_q != IDLE);
  assign bus.eoc_out     = eoc_q;
  assign bus.channel_out = chan_q;
  assign bus.overlap_err = ovl_q;

endmodule

// File: doc/drp_adc_responder.md
Name: drp_adc_responder

Overview:
- DRP-compatible responder emulating the XADC register interface.
- Stores the latest auxiliary-channel samples and answers den/daddr reads with do_out/drdy_out after a fixed latency.
- Used as the drop-in slave behind the joystick XADC reader, for boards with an external ADC and for system-level simulation without the XADC primitive.
- Samples arrive from an external ADC front-end through a valid-qualified push port.

Parameters:
- READ_LATENCY, 4, cycles from the den_in cycle to the drdy_out pulse; legal range 1..15.
- CFG0_RESET, 16'h0000, reset value of config register 0x40.
- CFG1_RESET, 16'h0000, reset value of config register 0x41.

Ports:
- clk_100MHz  input  1  DRP clock; sole clock.
- rst  input  1  synchronous, active-high reset.
- den_in  input  1  DRP enable; one-cycle request strobe.
- dwe_in  input  1  write enable, sampled with den_in.
- daddr_in  input  7  register address, sampled with den_in.
- di_in  input  16  write data, sampled with den_in.
- do_out  output  16  read data, valid only while drdy_out=1.
- drdy_out  output  1  one-cycle response strobe.
- busy_out  output  1  high while a request is pending.
- sample_valid  input  1  new ADC sample present.
- sample_ch  input  1  0 = aux6 (X axis), 1 = aux7 (Y axis).
- sample_data  input  12  unsigned conversion result.
- eoc_out  output  1  one-cycle end-of-conversion pulse.
- channel_out  output  7  channel of the last stored sample (7'h16 or 7'h17).
- overlap_err  output  1  sticky flag: den_in arrived while busy.

Behaviour:
- Reset values: do_out=0, drdy_out=0, busy_out=0, eoc_out=0, channel_out=0, overlap_err=0, aux6/aux7 registers=0, 0x40=CFG0_RESET, 0x41=CFG1_RESET.
- Address map:
  - 0x16: aux6 result, read-only, format {data[11:0],4'b0000}.
  - 0x17: aux7 result, same format.
  - 0x40/0x41: config registers, read/write.
  - Any other address reads 16'h0000; writes to it are ignored.
- FSM states: IDLE, WAIT, RESP.
  - IDLE + den_in: latch dwe_in/daddr_in/di_in. For a read, capture the addressed register into a holding register in the same cycle. Load counter=READ_LATENCY-1. busy_out=1 from the next cycle. Go to WAIT (straight to RESP if READ_LATENCY=1).
  - WAIT: decrement the counter; at 0 go to RESP.
  - RESP: drdy_out=1 for exactly this cycle; do_out=holding register for reads, 0 for writes. Writes commit to the register in this cycle. busy_out=0 next cycle. Return to IDLE.
- Latency: drdy_out asserts exactly READ_LATENCY cycles after the den_in cycle.
- Read-snapshot rule: a read returns the value present in the den_in cycle. A sample landing on the same register in that cycle or later is not visible until the next read.
- den_in while busy (WAIT or RESP): the request is dropped, overlap_err is set (sticky until rst), and the in-flight transaction is unaffected.
- den_in in the cycle after RESP is accepted normally, giving back-to-back throughput of one request per READ_LATENCY+1 cycles.
- Sample path:
  - On sample_valid, store {sample_data,4'b0} into aux6 or aux7 per sample_ch.
  - Next cycle: eoc_out=1 for one cycle and channel_out updates to 7'h16 or 7'h17.
  - Consecutive valid cycles each produce their own eoc_out pulse.
  - The sample path runs independently of the DRP FSM.
- rst mid-transaction: the FSM returns to IDLE, no drdy_out is issued, and pending writes are discarded.

Optional Feature:
- DRP_WRITE_EN defined: dwe_in=1 requests write 0x40/0x41 as above.
- DRP_WRITE_EN undefined: all writes are ignored and config registers hold their reset values. The transaction still completes, with drdy_out pulsing at READ_LATENCY and do_out=0, so the initiator never hangs.

Test Plan:
- Reset, then sample_valid with ch=0, data=12'h7D0 -> eoc_out pulse next cycle, channel_out=7'h16. Then den_in read 0x16 -> drdy_out exactly 4 cycles later, do_out=16'h7D00.
- Read 0x17 with a ch=1, data=12'hBB8 sample pushed in the same cycle as den_in -> do_out=16'h0000 (old value). A second read returns 16'hBB80.
- den_in issued 2 cycles after an accepted read -> one drdy_out only, overlap_err=1 and stays 1 until rst.
- With DRP_WRITE_EN: write 0x40=16'hA5A5, then read 0x40 -> 16'hA5A5. Without DRP_WRITE_EN: the same read returns CFG0_RESET, and the write still produced drdy_out.
- Read of unmapped 0x05 -> drdy_out with do_out=0. With READ_LATENCY=1, drdy_out arrives the cycle after den_in.
- Assert rst 2 cycles into a read -> no drdy_out, busy_out=0. A new read immediately after rst deasserts completes normally.
